i2c_master: RTL and testbench
=============================

# i2c_master

Byte-level I2C master controller that sequences the shared open-drain SCL/SDA bus pair of the I2C interface. A host issues START, STOP, WRITE-byte and READ-byte commands over a valid/ready port. The block generates the bus waveforms through open-drain enables and returns one response per command. It sits between a register/bus-functional front end and the bus wires: `scl_oe`/`sda_oe` pull the wire low, and a released wire floats high via pull-up.

## Interface
- `QDIV`, default 125: clk cycles per quarter SCL period (125 gives 100 kHz at 50 MHz); legal range 2..65535.
- `clk` input 1: single system clock; all logic rises on posedge.
- `rst` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command; high only in IDLE.
- `cmd` input 2: 00 START, 01 STOP, 10 WRITE, 11 READ.
- `cmd_data` input 8: byte to transmit on WRITE; ignored otherwise.
- `cmd_nack` input 1: on READ, 1 = master sends NACK in the 9th bit, 0 = ACK.
- `rsp_valid` output 1: one-cycle pulse when a command completes.
- `rsp_data` output 8: byte received on READ; holds its previous value for other commands.
- `rsp_ack` output 1: on WRITE, 1 if the slave drove ACK (SDA low); 0 for all other commands.
- `busy` output 1: high from command acceptance until the `rsp_valid` cycle.
- `scl_i`, `sda_i` input 1 each: bus line levels, asynchronous to `clk`.
- `scl_oe`, `sda_oe` output 1 each: 1 = drive the line low, 0 = release it.

## Operation
- **Handshake.** A command is accepted in the cycle where `cmd_valid && cmd_ready`. `cmd`, `cmd_data` and `cmd_nack` are registered on acceptance.
- **Input sync.** `scl_i` and `sda_i` pass through 2-flop synchronizers before any use.
- **State machine.** States are IDLE, START, BIT, STOP, RESP.
  - IDLE goes to START, BIT or STOP according to `cmd`.
  - START and STOP go to RESP after their 4 quarters.
  - BIT runs 9 bits, then goes to RESP.
  - RESP pulses `rsp_valid` and returns to IDLE.
- **Quarter counter.** Counts 0..QDIV-1. A 2-bit phase (q0..q3) advances when the counter wraps.
- **START** (also valid as a repeated start):
  - q0: release SDA; SCL keeps its current state.
  - q1: release SCL.
  - q2: drive SDA low.
  - q3: drive SCL low.
- **BIT**, per bit:
  - q0: SCL low; set `sda_oe` = !bit.
  - q1: release SCL.
  - q2: SCL high; sample synced SDA on the last cycle of q2.
  - q3: drive SCL low.
- **Bit order.** Bits 0..7 go MSB first.
- **WRITE.** Bits 0..7 use `cmd_data`. Bit 8 releases SDA and samples ACK: `rsp_ack` = !sampled.
- **READ.** Bits 0..7 release SDA and shift the sampled values into `rsp_data`. Bit 8 drives SDA low if `cmd_nack` = 0.
- **STOP:**
  - q0: drive SDA low with SCL low.
  - q1: release SCL.
  - q2: release SDA.
  - q3: hold both released.
- **Idle level.** After STOP both lines are released. After START, WRITE or READ, SCL stays driven low.
- **Mid-operation reset.** `rst` low clears all state immediately and releases both lines. No STOP is generated.
- **No cross-checking.** The block does not check command legality against bus state. For example, a WRITE without a prior START is executed as-is.

## Timing
- Reset values:
  - `cmd_ready`=1
  - `rsp_valid`=0
  - `rsp_data`=8'h00
  - `rsp_ack`=0
  - `busy`=0
  - `scl_oe`=0
  - `sda_oe`=0
- Latency without stretching, with acceptance at cycle t:
  - START/STOP: `rsp_valid` at t+4·QDIV+1.
  - WRITE/READ: `rsp_valid` at t+36·QDIV+1.
- `cmd_ready` is low from t+1 through the `rsp_valid` cycle, and high again the cycle after.
- `scl_oe`/`sda_oe` are registered outputs. Each change lands on the first cycle of its quarter.
- Back-to-back commands add exactly 1 idle cycle (the RESP cycle).

## Configuration
- `I2C_MASTER_STRETCH_EN` defined: clock stretching is supported.
  - In every q1 where SCL is released, the quarter counter holds at 0 while synced SCL reads 0.
  - q1 begins counting only once SCL is seen high, so a slave holding SCL low extends the command.
- Not defined: `scl_i` is used only through the synchronizer and is otherwise ignored; timing is strictly fixed.

## Test plan
- **Reset.** With QDIV=4, hold `rst`=0 -> all outputs at reset values, both lines released.
- **START timing.** With QDIV=4, issue START -> SDA falls while SCL is high. `rsp_valid` pulses exactly 17 cycles after acceptance, `rsp_ack`=0, and SCL is left low.
- **WRITE with ACK.** WRITE 8'hA5 with the slave model pulling SDA low in bit 8 -> sampled bits read 1,0,1,0,0,1,0,1, `rsp_ack`=1, `rsp_valid` at 145 cycles. Repeat with no slave ACK -> `rsp_ack`=0.
- **READ with NACK.** Slave model drives 8'h3C, READ with `cmd_nack`=1 -> `rsp_data`=8'h3C and `sda_oe`=0 throughout bit 8. Repeat with `cmd_nack`=0 -> `sda_oe`=1 during bit 8.
- **Clock stretch.** With `I2C_MASTER_STRETCH_EN` defined, the slave holds SCL low for 20 cycles in bit 3 of a WRITE -> `rsp_valid` is delayed by 20 plus synchronizer cycles. Without the macro the response timing is unchanged at 145 cycles.
- **Reset mid-WRITE.** Assert `rst` during bit 4 of a WRITE -> `scl_oe`=`sda_oe`=0 asynchronously, no `rsp_valid`, and `cmd_ready`=1 on the first clock after release.

Source files
------------

// File: rtl/i2c_master_if.sv
// i2c_master_if: host command/response port plus the open-drain SCL/SDA pair.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; the host holds cmd, cmd_data and cmd_nack stable
// while cmd_valid is high. There is no response back-pressure: rsp_valid is a
// single-cycle pulse and rsp_data/rsp_ack are meaningful in that cycle.
// fsm_state mirrors the controller state for debug and checkers.
interface i2c_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] cmd_data;
    logic       cmd_nack;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ack;
    logic       busy;
    logic       scl_i;
    logic       sda_i;
    logic       scl_oe;
    logic       sda_oe;
    logic [2:0] fsm_state;

    modport master (
        input  cmd_valid, cmd, cmd_data, cmd_nack, scl_i, sda_i,
        output cmd_ready, rsp_valid, rsp_data, rsp_ack, busy, scl_oe, sda_oe, fsm_state
    );

    modport slave (
        output cmd_valid, cmd, cmd_data, cmd_nack, scl_i, sda_i,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ack, busy, scl_oe, sda_oe, fsm_state
    );
endinterface

// File: rtl/i2c_master.sv
// i2c_master: byte-level I2C master. Executes START, STOP, WRITE and READ
// commands, one response per command, driving SCL/SDA via open-drain enables.
// Each bus step is one quarter of an SCL period (QDIV clk cycles).
// Optional macro I2C_MASTER_STRETCH_EN: honour slave clock stretching by
// holding the quarter counter in q1 until SCL is seen high.
module i2c_master #(
    parameter int unsigned QDIV = 125
) (
    input  logic         clk,
    input  logic         rst,
    i2c_master_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_STOP  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    state_t      state, next_state;
    logic [15:0] qcnt;
    logic [1:0]  phase;
    logic [3:0]  bit_idx;
    logic [1:0]  cmd_r;
    logic [7:0]  data_r;
    logic        nack_r;
    logic [7:0]  rx_sh;
    logic [7:0]  rsp_data_r;
    logic        rsp_ack_r;
    logic        scl_oe_r, sda_oe_r;
    logic        scl_nxt, sda_nxt;
    logic        scl_s1, scl_s, sda_s1, sda_s;
    logic        accept, active, hold, qdone, last_q, drive_bit;
    logic [1:0]  np;
    logic [3:0]  nb;

    assign accept = (state == S_IDLE) && bus.cmd_valid;
    assign active = (state == S_START) || (state == S_BIT) || (state == S_STOP);

`ifdef I2C_MASTER_STRETCH_EN
    // A slave holding SCL low freezes the first cycle of q1.
    assign hold = active && (phase == 2'd1) && (qcnt == 16'd0) && !scl_s;
`else
    logic unused_scl;
    assign unused_scl = scl_s;
    assign hold = 1'b0;
`endif

    assign qdone  = active && !hold && (qcnt == 16'(QDIV - 1));
    assign last_q = qdone && (phase == 2'd3);

    // Upcoming phase and bit index, used to pre-compute registered line levels.
    assign np = phase + 2'd1;
    assign nb = (phase == 2'd3) ? bit_idx + 4'd1 : bit_idx;

    // Two-flop synchronizers; lines idle high through the pull-ups.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_s1 <= 1'b1;
            scl_s  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s  <= 1'b1;
        end else begin
            scl_s1 <= bus.scl_i;
            scl_s  <= scl_s1;
            sda_s1 <= bus.sda_i;
            sda_s  <= sda_s1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd)
                        CMD_START: next_state = S_START;
                        CMD_STOP:  next_state = S_STOP;
                        default:   next_state = S_BIT;
                    endcase
                end
            end
            S_START, S_STOP: if (last_q) next_state = S_RESP;
            S_BIT:           if (last_q && bit_idx == 4'd8) next_state = S_RESP;
            S_RESP:          next_state = S_IDLE;
            default:         next_state = S_IDLE;
        endcase
    end

    // Output logic: line levels for the quarter about to begin, plus status.
    always_comb begin
        scl_nxt   = scl_oe_r;
        sda_nxt   = sda_oe_r;
        if (cmd_r == CMD_WRITE) drive_bit = (nb < 4'd8) ? !data_r[3'd7 - nb[2:0]] : 1'b0;
        else                    drive_bit = (nb == 4'd8) && !nack_r;
        if (accept) begin
            case (bus.cmd)
                CMD_START: sda_nxt = 1'b0;
                CMD_STOP:  begin scl_nxt = 1'b1; sda_nxt = 1'b1; end
                CMD_WRITE: begin scl_nxt = 1'b1; sda_nxt = !bus.cmd_data[7]; end
                default:   begin scl_nxt = 1'b1; sda_nxt = 1'b0; end
            endcase
        end else if (qdone && next_state != S_RESP) begin
            case (state)
                S_START: begin
                    case (np)
                        2'd1:    scl_nxt = 1'b0;
                        2'd2:    sda_nxt = 1'b1;
                        2'd3:    scl_nxt = 1'b1;
                        default: ;
                    endcase
                end
                S_BIT: begin
                    case (np)
                        2'd0:    begin scl_nxt = 1'b1; sda_nxt = drive_bit; end
                        2'd1:    scl_nxt = 1'b0;
                        2'd3:    scl_nxt = 1'b1;
                        default: ;
                    endcase
                end
                S_STOP: begin
                    case (np)
                        2'd1:    scl_nxt = 1'b0;
                        2'd2:    sda_nxt = 1'b0;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_ack   = rsp_ack_r;
    assign bus.scl_oe    = scl_oe_r;
    assign bus.sda_oe    = sda_oe_r;
    assign bus.fsm_state = state;

    // Registered open-drain enables: each change lands on a quarter's first cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_oe_r <= 1'b0;
            sda_oe_r <= 1'b0;
        end else begin
            scl_oe_r <= scl_nxt;
            sda_oe_r <= sda_nxt;
        end
    end

    // Command capture, quarter/bit timing and receive datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_r      <= 2'b00;
            data_r     <= 8'h00;
            nack_r     <= 1'b0;
            qcnt       <= 16'd0;
            phase      <= 2'd0;
            bit_idx    <= 4'd0;
            rx_sh      <= 8'h00;
            rsp_data_r <= 8'h00;
            rsp_ack_r  <= 1'b0;
        end else begin
            if (accept) begin
                cmd_r     <= bus.cmd;
                data_r    <= bus.cmd_data;
                nack_r    <= bus.cmd_nack;
                qcnt      <= 16'd0;
                phase     <= 2'd0;
                bit_idx   <= 4'd0;
                rsp_ack_r <= 1'b0;
            end else if (active && !hold) begin
                if (qdone) begin
                    qcnt  <= 16'd0;
                    phase <= phase + 2'd1;
                    if (phase == 2'd3) bit_idx <= bit_idx + 4'd1;
                end else begin
                    qcnt <= qcnt + 16'd1;
                end
            end
            // SDA is sampled on the last cycle of q2, while SCL is high.
            if (state == S_BIT && qdone && phase == 2'd2) begin
                if (bit_idx < 4'd8)          rx_sh     <= {rx_sh[6:0], sda_s};
                else if (cmd_r == CMD_WRITE) rsp_ack_r <= !sda_s;
            end
            if (state == S_BIT && last_q && bit_idx == 4'd8 && cmd_r == CMD_READ)
                rsp_data_r <= rx_sh;
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: drives i2c_master (QDIV=4) against a slave/bus model and a
// behavioural response/timing model.
module tb_i2c_master;
    localparam int unsigned QDIV = 4;
    localparam int LAT_SHORT = 4 * QDIV + 1;
    localparam int LAT_LONG  = 36 * QDIV + 1;
    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_master_if bus();
    i2c_master #(.QDIV(QDIV)) dut (.clk(clk), .rst(rst), .bus(bus));

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Open-drain bus with a slave model: pull for bit k is pull_vec[8-k]
    logic       slave_on = 1'b0;
    logic       slave_scl_pull = 1'b0;
    logic       slave_sda_pull;
    logic [8:0] pull_vec = 9'h000;
    int         fall_cnt = 0;
    int         rise_cnt = 0;
    logic       rise_sda [9];
    logic       rise_oe  [9];
    int         start_cnt = 0;
    int         stop_cnt = 0;
    logic       scl_bus, sda_bus;

    always_comb begin
        slave_sda_pull = 1'b0;
        if (slave_on && fall_cnt >= 0 && fall_cnt < 9) slave_sda_pull = pull_vec[8 - fall_cnt];
    end
    assign scl_bus   = !(bus.scl_oe || slave_scl_pull);
    assign sda_bus   = !(bus.sda_oe || slave_sda_pull);
    assign bus.scl_i = scl_bus;
    assign bus.sda_i = sda_bus;

    always @(negedge scl_bus) if (slave_on) fall_cnt++;
    always @(posedge scl_bus) begin
        if (slave_on && rise_cnt < 9) begin
            rise_sda[rise_cnt] = sda_bus;
            rise_oe[rise_cnt]  = bus.sda_oe;
            rise_cnt++;
        end
    end
    always @(negedge sda_bus) if (scl_bus) start_cnt++;
    always @(posedge sda_bus) if (scl_bus) stop_cnt++;

    // Scoreboard: expected {rsp_ack, rsp_data} per command, plus timing model
    logic [8:0] exp_q[$];
    logic [7:0] exp_data = 8'h00;
    logic       pending = 1'b0;
    int         t_acc = 0;
    int         nom_lat = 0;
    logic       cur_read_nack1 = 1'b0;
    logic       exp_busy;
    logic [8:0] exp_rsp;
    int         lat_min_extra = 0;
    int         lat_max_extra = 40;

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_cmd_ready", bus.cmd_ready, 1);
            check("reset_rsp_valid", bus.rsp_valid, 0);
            check("reset_rsp_data", bus.rsp_data, 8'h00);
            check("reset_rsp_ack", bus.rsp_ack, 0);
            check("reset_busy", bus.busy, 0);
            check("reset_scl_oe", bus.scl_oe, 0);
            check("reset_sda_oe", bus.sda_oe, 0);
        end else begin
`ifndef I2C_MASTER_STRETCH_EN
            exp_busy = pending && (cyc > t_acc) && (cyc <= t_acc + nom_lat);
            check("busy", bus.busy, exp_busy);
            check("cmd_ready", bus.cmd_ready, !exp_busy);
            check("rsp_valid", bus.rsp_valid, pending && (cyc == t_acc + nom_lat));
`endif
            if (bus.rsp_valid) begin
                check("rsp_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_rsp = exp_q.pop_front();
                    check("rsp_data", bus.rsp_data, exp_rsp[7:0]);
                    check("rsp_ack", bus.rsp_ack, exp_rsp[8]);
                end
            end
            if (cur_read_nack1 && fall_cnt >= 8 && bus.busy) check("nack_bit8_sda_oe", bus.sda_oe, 0);
        end
    end

    // Driver: issue one command and wait for its response
    task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input logic nk,
                          input logic [8:0] pv, input bit bit_chk, output int lat);
        int  s0, p0;
        bit  seen;
        lat  = -1;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = bus.cmd_ready;
        end
        if (!seen) begin
            check("cmd_ready_timeout", 0, 1);
            return;
        end
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.cmd_data  = d;
        bus.cmd_nack  = nk;
        s0 = start_cnt;
        p0 = stop_cnt;
        if (c[1]) begin
            fall_cnt = 0;
            rise_cnt = 0;
            pull_vec = pv;
            slave_on = 1'b1;
        end
        cur_read_nack1 = (c == CMD_READ) && nk;
        if (c == CMD_READ) exp_data = ~pv[8:1];
        exp_q.push_back({(c == CMD_WRITE) && pv[0], exp_data});
        t_acc   = cyc;
        nom_lat = c[1] ? LAT_LONG : LAT_SHORT;
        pending = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'($urandom_range(0, 3));
        bus.cmd_data  = 8'($urandom_range(0, 255));
        bus.cmd_nack  = 1'($urandom_range(0, 1));
        seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            seen = bus.rsp_valid;
        end
        if (!seen) begin
            check("rsp_timeout", 0, 1);
            exp_q.delete();
            slave_on = 1'b0;
            cur_read_nack1 = 1'b0;
            return;
        end
        lat = cyc - t_acc;
`ifndef I2C_MASTER_STRETCH_EN
        check("latency", lat, nom_lat);
`else
        check("latency_range", (lat >= nom_lat + lat_min_extra) && (lat <= nom_lat + lat_max_extra), 1);
`endif
        if (c == CMD_START) begin
            check("start_cond", start_cnt - s0, 1);
            check("start_scl_low", bus.scl_oe, 1);
        end
        if (c == CMD_STOP) begin
            check("stop_cond", stop_cnt - p0, 1);
            check("stop_scl_rel", bus.scl_oe, 0);
            check("stop_sda_rel", bus.sda_oe, 0);
        end
        if (c[1] && bit_chk) begin
            check("scl_pulses", rise_cnt, 9);
            for (int k = 0; k < 8; k++) begin
                if (c == CMD_WRITE) check("write_bit", rise_sda[k], d[7 - k]);
                else                check("read_release", rise_oe[k], 0);
            end
            check("bit8_sda_oe", rise_oe[8], (c == CMD_READ) && !nk);
            check("after_scl_low", bus.scl_oe, 1);
        end
        slave_on = 1'b0;
        cur_read_nack1 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [7:0] b;
        logic ab;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        bus.cmd_data  = 8'h00;
        bus.cmd_nack  = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_state_idle", bus.fsm_state, 0);
        #1 rst = 1'b1;

        // START then WRITE A5 with ACK, WRITE without ACK
        do_cmd(CMD_START, 8'h00, 1'b0, 9'h000, 1'b1, lat);
`ifndef I2C_MASTER_STRETCH_EN
        check("start_lat_17", lat, 17);
`endif
        check("start_ack_0", bus.rsp_ack, 0);
        do_cmd(CMD_WRITE, 8'hA5, 1'b0, 9'h001, 1'b1, lat);
`ifndef I2C_MASTER_STRETCH_EN
        check("write_lat_145", lat, 145);
`endif
        check("write_ack_1", bus.rsp_ack, 1);
        do_cmd(CMD_WRITE, 8'h5A, 1'b0, 9'h000, 1'b1, lat);
        check("write_noack_0", bus.rsp_ack, 0);

        // READ 3C with NACK then with ACK
        do_cmd(CMD_READ, 8'h00, 1'b1, {~8'h3C, 1'b0}, 1'b1, lat);
        check("read_data_3c", bus.rsp_data, 8'h3C);
        do_cmd(CMD_READ, 8'h00, 1'b0, {~8'h3C, 1'b0}, 1'b1, lat);
        check("read_ack_drive", rise_oe[8], 1);
        do_cmd(CMD_STOP, 8'h00, 1'b0, 9'h000, 1'b1, lat);
        check("stop_keeps_data", bus.rsp_data, 8'h3C);

        // Randomized transactions
        for (int r = 0; r < 3; r++) begin
            do_cmd(CMD_START, 8'h00, 1'b0, 9'h000, 1'b1, lat);
            for (int j = 0; j < 3; j++) begin
                b  = 8'($urandom_range(0, 255));
                ab = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) do_cmd(CMD_WRITE, b, 1'b0, {8'h00, ab}, 1'b1, lat);
                else                          do_cmd(CMD_READ, 8'h00, ab, {~b, 1'b0}, 1'b1, lat);
            end
            do_cmd(CMD_STOP, 8'h00, 1'b0, 9'h000, 1'b1, lat);
        end

        // Slave holds SCL low for 20 cycles in bit 3 of a WRITE
        do_cmd(CMD_START, 8'h00, 1'b0, 9'h000, 1'b1, lat);
        lat_min_extra = 20;
        lat_max_extra = 70;
        fall_cnt = 0;
        fork
            do_cmd(CMD_WRITE, 8'hC3, 1'b0, 9'h000, 1'b0, lat);
            begin
                bit hit;
                hit = 0;
                for (int i = 0; i < 400 && !hit; i++) begin
                    @(negedge clk);
                    hit = slave_on && (fall_cnt == 3);
                end
                check("stretch_arm", hit, 1);
                slave_scl_pull = 1'b1;
                hit = 0;
                for (int i = 0; i < 200 && !hit; i++) begin
                    @(negedge clk);
                    hit = !bus.scl_oe;
                end
                repeat (20) @(negedge clk);
                slave_scl_pull = 1'b0;
            end
        join
`ifndef I2C_MASTER_STRETCH_EN
        check("stretch_ignored_145", lat, 145);
`endif
        lat_min_extra = 0;
        lat_max_extra = 40;

        // Reset during bit 4 of a WRITE
        do_cmd(CMD_START, 8'h00, 1'b0, 9'h000, 1'b1, lat);
        @(negedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd       = CMD_WRITE;
        bus.cmd_data  = 8'h00;
        fall_cnt = 0;
        rise_cnt = 0;
        pull_vec = 9'h000;
        slave_on = 1'b1;
        exp_q.push_back({1'b0, exp_data});
        t_acc = cyc;
        nom_lat = LAT_LONG;
        pending = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 400 && !hit; i++) begin
                @(negedge clk);
                hit = (fall_cnt == 4);
            end
            check("midrst_reach_bit4", hit, 1);
        end
        repeat (6) @(negedge clk);
        #1;
        rst = 1'b0;
        pending = 1'b0;
        slave_on = 1'b0;
        exp_q.delete();
        exp_data = 8'h00;
        #1;
        check("midrst_scl_rel", bus.scl_oe, 0);
        check("midrst_sda_rel", bus.sda_oe, 0);
        check("midrst_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", bus.cmd_ready, 1);
        do_cmd(CMD_START, 8'h00, 1'b0, 9'h000, 1'b1, lat);
        do_cmd(CMD_STOP, 8'h00, 1'b0, 9'h000, 1'b1, lat);
        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule
